// File: rtl/eda_regional_max_ctrl.sv
// eda_regional_max_ctrl: loads a raster frame into the image RAM, then scans every pixel through the regional-max datapath.
// Optional WAIT watchdog and sticky timeout_err port are enabled by defining EDA_CTRL_TIMEOUT_EN.
module eda_regional_max_ctrl #(
    parameter int M           = 6,
    parameter int N           = 6,
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = $clog2(M*N),
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    output logic                   write_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [ADDR_WIDTH-1:0]  center_addr,
    output logic                   clear,
    output logic                   new_pixel,
    input  logic                   cmp_valid,
    input  logic                   cmp_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_data,
    output logic                   done,
`ifdef EDA_CTRL_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    output logic                   busy
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(M*N-1);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, ISSUE, WAIT, EMIT, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pix_cnt;
`ifdef EDA_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT+1);
    logic [WD_W-1:0] wd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            in_ready    <= 1'b0;
            write_en    <= 1'b0;
            wr_addr     <= '0;
            pixel_in    <= '0;
            center_addr <= '0;
            clear       <= 1'b0;
            new_pixel   <= 1'b0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_data    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
`ifdef EDA_CTRL_TIMEOUT_EN
            wd          <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            write_en  <= 1'b0;
            clear     <= 1'b0;
            new_pixel <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    pix_cnt  <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
`ifdef EDA_CTRL_TIMEOUT_EN
                    timeout_err <= 1'b0;
`endif
                end
                LOAD: if (in_valid && in_ready) begin
                    write_en <= 1'b1;
                    wr_addr  <= pix_cnt;
                    pixel_in <= in_data;
                    // terminal count compared explicitly so the counter never wraps
                    if (pix_cnt == LAST) begin
                        in_ready    <= 1'b0;
                        center_addr <= '0;
                        clear       <= 1'b1;
                        state       <= CLEAR;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    new_pixel <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef EDA_CTRL_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                WAIT: if (cmp_valid) begin
                    out_data  <= cmp_result;
                    out_valid <= 1'b1;
                    out_addr  <= center_addr;
                    state     <= EMIT;
                end
`ifdef EDA_CTRL_TIMEOUT_EN
                else if (wd == WD_W'(TIMEOUT-1)) begin
                    out_data    <= 1'b0;
                    out_valid   <= 1'b1;
                    out_addr    <= center_addr;
                    timeout_err <= 1'b1;
                    state       <= EMIT;
                end else begin
                    wd <= wd + 1'b1;
                end
`endif
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (center_addr == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        center_addr <= center_addr + 1'b1;
                        clear       <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eda_regional_max_ctrl.sv
// tb_eda_regional_max_ctrl: frame-level model of the sequencer checked every cycle, plus literal per-frame totals.
// Timeout scenarios are included when EDA_CTRL_TIMEOUT_EN is defined.
module tb_eda_regional_max_ctrl;
    localparam int M = 6, N = 6, PW = 8, AW = $clog2(M*N), NPIX = M*N, TMO = 8;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic cmp_valid = 1'b0, cmp_result = 1'b0, out_ready = 1'b1;
    logic [PW-1:0] in_data = '0;
    logic in_ready, write_en, clear, new_pixel, out_valid, out_data, done, busy, timeout_err;
    logic [AW-1:0] wr_addr, center_addr, out_addr;
    logic [PW-1:0] pixel_in;

    always #5 clk = ~clk;

    eda_regional_max_ctrl #(.M(M), .N(N), .PIXEL_WIDTH(PW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
        .center_addr(center_addr), .clear(clear), .new_pixel(new_pixel),
        .cmp_valid(cmp_valid), .cmp_result(cmp_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .done(done),
`ifdef EDA_CTRL_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .busy(busy)
    );
`ifndef EDA_CTRL_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    int vectors = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // datapath and sink behaviour knobs
    int dp_hot = 14, dp_delay = 3, dp_sp_addr = -1, dp_sp_delay = 0;
    int stall_addr = 7, stall_left = 0;

    // model state
    bit hs_prev, ld_m, busy_m, clr_due, np_due, ov_exp, res_exp, done_due, in_wait, tmo_m;
    int acc, wr_exp, exp_center, wcnt;
    logic [PW-1:0] wq[$];
    int n_wr, n_res, n_ones, one_addr, n_done, n_stall;
    bit hs, ohs, nclr, dn, accept;

    // datapath: answers (addr == dp_hot) a fixed number of cycles after new_pixel
    initial begin : datapath
        int cd, pa;
        cd = 0; pa = 0;
        forever begin
            @(posedge clk); #1;
            cmp_valid = 1'b0;
            cmp_result = 1'b1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    cmp_valid = 1'b1;
                    cmp_result = (pa == dp_hot);
                end
            end
            if (new_pixel) begin
                pa = int'(center_addr);
                cd = (pa == dp_sp_addr) ? dp_sp_delay : dp_delay;
            end
        end
    end

    initial begin : sink
        forever begin
            @(posedge clk); #1;
            if (out_valid && int'(out_addr) == stall_addr && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outputs", {in_ready, write_en, wr_addr, pixel_in, center_addr, clear, new_pixel,
                                      out_valid, out_addr, out_data, done, busy, timeout_err}, 64'd0);
                hs_prev = 0; ld_m = 0; busy_m = 0; clr_due = 0; np_due = 0; ov_exp = 0;
                done_due = 0; in_wait = 0; tmo_m = 0; acc = 0; wr_exp = 0; exp_center = 0;
                wq.delete();
            end else begin
                chk("write_en", write_en, hs_prev);
                if (write_en && wq.size() > 0) begin
                    chk("wr_addr", wr_addr, wr_exp);
                    chk("pixel_in", pixel_in, wq.pop_front());
                    wr_exp++;
                    n_wr++;
                end
                chk("in_ready", in_ready, ld_m);
                chk("busy", busy, busy_m);
                chk("clear", clear, clr_due);
                chk("new_pixel", new_pixel, np_due);
                if (clear || new_pixel || out_valid || in_wait) chk("center_addr", center_addr, exp_center);
                chk("out_valid", out_valid, ov_exp);
                if (out_valid) begin
                    chk("out_addr", out_addr, exp_center);
                    chk("out_data", out_data, res_exp);
                    if (int'(out_addr) == stall_addr) n_stall++;
                end
                chk("done", done, done_due);
`ifdef EDA_CTRL_TIMEOUT_EN
                chk("timeout_err", timeout_err, tmo_m);
`endif
                if (done) n_done++;
                hs = in_valid && in_ready;
                ohs = out_valid && out_ready;
                nclr = 0;
                dn = 0;
                accept = start && !busy_m;
                hs_prev = hs;
                if (hs) begin
                    wq.push_back(in_data);
                    acc++;
                    if (acc == NPIX) begin
                        ld_m = 0;
                        nclr = 1;
                        exp_center = 0;
                    end
                end
                np_due = clear;
                if (new_pixel) begin
                    in_wait = 1;
                    wcnt = 0;
                end else if (in_wait) begin
                    wcnt++;
                    if (cmp_valid) begin
                        ov_exp = 1;
                        res_exp = (exp_center == dp_hot);
                        in_wait = 0;
                    end
`ifdef EDA_CTRL_TIMEOUT_EN
                    else if (wcnt == TMO) begin
                        ov_exp = 1;
                        res_exp = 0;
                        tmo_m = 1;
                        in_wait = 0;
                    end
`endif
                end
                if (ohs) begin
                    ov_exp = 0;
                    n_res++;
                    if (out_data) begin
                        n_ones++;
                        one_addr = int'(out_addr);
                    end
                    if (exp_center == NPIX-1) dn = 1;
                    else begin
                        exp_center++;
                        nclr = 1;
                    end
                end
                clr_due = nclr;
                if (done_due) busy_m = 0;
                done_due = dn;
                if (accept) begin
                    busy_m = 1; ld_m = 1; acc = 0; wr_exp = 0; tmo_m = 0;
                    n_wr = 0; n_res = 0; n_ones = 0; one_addr = -1; n_done = 0; n_stall = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic load_pixels(input bit toggle, input int count);
        int k, c;
        k = 0; c = 0;
        while (k < count && c < 500) begin
            @(posedge clk); #1;
            in_valid = toggle ? (c % 2 == 0) : 1'b1;
            in_data = PW'(k * 37 + 5);
            @(negedge clk);
            if (in_valid && in_ready) k++;
            c++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("load_handshakes", k, count);
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (n_done == 0 && c < 4000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1 chk("frame_done_count", n_done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // frame aborted by reset after 10 pixels
        pulse_start();
        load_pixels(0, 10);
        @(posedge clk); #1 chk("abort_writes", n_wr, 10);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("abort_no_extra_writes", n_wr, 10);
        chk("abort_no_results", n_res, 0);
        chk("abort_no_done", n_done, 0);
        // full load, hot pixel 14, sink stall at 7, a stray start mid-scan
        stall_left = 5;
        pulse_start();
        load_pixels(0, NPIX);
        repeat (20) @(posedge clk);
        pulse_start();
        wait_done();
        chk("b_writes", n_wr, 36);
        chk("b_results", n_res, 36);
        chk("b_ones", n_ones, 1);
        chk("b_one_addr", one_addr, 14);
        chk("b_stall_cycles", n_stall, 6);
        // toggling in_valid load
        pulse_start();
        load_pixels(1, NPIX);
        wait_done();
        chk("c_writes", n_wr, 36);
        chk("c_results", n_res, 36);
        chk("c_ones", n_ones, 1);
        chk("c_one_addr", one_addr, 14);
`ifdef EDA_CTRL_TIMEOUT_EN
        // datapath silent at addr 3: forced 0 and sticky error
        dp_hot = 3; dp_sp_addr = 3; dp_sp_delay = 0;
        pulse_start();
        load_pixels(0, NPIX);
        wait_done();
        chk("d_timeout_err", timeout_err, 1);
        chk("d_results", n_res, 36);
        chk("d_ones", n_ones, 0);
        // answer lands on the expiry cycle: real result wins
        dp_sp_delay = TMO;
        pulse_start();
        chk("e_timeout_cleared", timeout_err, 0);
        load_pixels(0, NPIX);
        wait_done();
        chk("e_timeout_err", timeout_err, 0);
        chk("e_ones", n_ones, 1);
        chk("e_one_addr", one_addr, 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
